// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register map,
// STATUS bit layout and UART serializer states.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;

  // Register selects are word offsets, i.e. addr[7:2].
  localparam logic [5:0] REG_TXDATA      = 6'h00;
  localparam logic [5:0] REG_STATUS      = 6'h01;
  localparam logic [5:0] REG_MTIME_LO    = 6'h02;
  localparam logic [5:0] REG_MTIME_HI    = 6'h03;
  localparam logic [5:0] REG_MTIMECMP_LO = 6'h04;
  localparam logic [5:0] REG_MTIMECMP_HI = 6'h05;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_EMPTY   = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

endpackage

// File: rtl/dmem_responder_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer with a per-bit
// down-counter; a frame ending with data pending starts the next one at once.
module uart_tx
  import dmem_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  input  logic                          clr_ovf,
  output logic                          tx_busy,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(BAUD_DIV - 1);
  localparam logic [AW:0]   DEPTH_CNT   = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, push_ok;

  uart_state_e   state, state_d;
  logic [BW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shifter, shift_d;
  logic          tx_d;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign tx_busy = (state != UART_IDLE);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UART_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shifter  <= shift_d;
      tx       <= tx_d;
    end
  end

  // tx is registered from the next-state view so the line changes together with the state.
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shifter;
    tx_d    = 1'b1;
    pop     = 1'b0;
    if (state != UART_IDLE) baud_d = baud_cnt - 1'b1;
    case (state)
      UART_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = UART_START;
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b0;
        end
      end
      UART_START: begin
        tx_d = 1'b0;
        if (baud_cnt == '0) begin
          state_d = UART_DATA;
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          tx_d    = shifter[0];
        end
      end
      UART_DATA: begin
        tx_d = shifter[0];
        if (baud_cnt == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_idx + 1'b1;
            shift_d = {1'b0, shifter[7:1]};
            tx_d    = shifter[1];
          end
        end
      end
      UART_STOP: begin
        tx_d = 1'b1;
        if (baud_cnt == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = UART_START;
            baud_d  = BAUD_RELOAD;
            tx_d    = 1'b0;
          end else begin
            state_d = UART_IDLE;
          end
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Port-B data-memory responder: BRAM passthrough plus an MMIO window with
// a UART transmitter and a 64-bit machine timer; loads return one cycle later.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0]  MMIO_BASE  = MMIO_BASE_DEF,
  parameter int unsigned  BAUD_DIV   = 868,
  parameter int unsigned  FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] core_addr,
  input  logic [3:0]  core_we,
  input  logic [31:0] core_wdata,
  input  logic        core_re,
  output logic [31:0] core_rdata,
  output logic [31:0] bram_addr,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_wdata,
  input  logic [31:0] bram_rdata,
  output logic        uart_tx,
  output logic        irq_timer
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          mmio_hit;
  logic [5:0]    reg_sel;
  logic [63:0]   mtime, mtime_d, mtimecmp, mtimecmp_d;
  logic          push, clr_ovf;
  logic          tx_busy, fifo_full, fifo_empty, tx_ovf;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word, mmio_rdata, mmio_rdata_q;
  logic          sel_mmio_q;
  logic          unused_addr;

  assign mmio_hit    = (core_addr[31:16] == MMIO_BASE[31:16]);
  assign reg_sel     = core_addr[7:2];
  assign unused_addr = ^{core_addr[15:8], core_addr[1:0]};

  assign bram_addr  = core_addr;
  assign bram_wdata = core_wdata;
  assign bram_we    = mmio_hit ? '0 : core_we;

  assign push    = mmio_hit && (reg_sel == REG_TXDATA) && core_we[0];
  assign clr_ovf = mmio_hit && (reg_sel == REG_STATUS) && core_we[0] && core_wdata[ST_OVF];

  uart_tx #(
    .BAUD_DIV   (BAUD_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (core_wdata[7:0]),
    .clr_ovf   (clr_ovf),
    .tx_busy   (tx_busy),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (tx_ovf),
    .count     (fifo_count),
    .tx        (uart_tx)
  );

  // Written bytes replace the incremented value, so they skip this cycle's tick.
  always_comb begin
    mtime_d    = mtime + 64'd1;
    mtimecmp_d = mtimecmp;
    if (mmio_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (core_we[b]) begin
          if (reg_sel == REG_MTIME_LO)    mtime_d[8*b +: 8]         = core_wdata[8*b +: 8];
          if (reg_sel == REG_MTIME_HI)    mtime_d[32+8*b +: 8]      = core_wdata[8*b +: 8];
          if (reg_sel == REG_MTIMECMP_LO) mtimecmp_d[8*b +: 8]      = core_wdata[8*b +: 8];
          if (reg_sel == REG_MTIMECMP_HI) mtimecmp_d[32+8*b +: 8]   = core_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    status_word                     = '0;
    status_word[ST_BUSY]            = tx_busy;
    status_word[ST_FULL]            = fifo_full;
    status_word[ST_EMPTY]           = fifo_empty;
    status_word[ST_OVF]             = tx_ovf;
    status_word[ST_CNT_LSB +: 4]    = 4'(fifo_count);
  end

  always_comb begin
    mmio_rdata = '0;
    case (reg_sel)
      REG_STATUS:      mmio_rdata = status_word;
      REG_MTIME_LO:    mmio_rdata = mtime[31:0];
      REG_MTIME_HI:    mmio_rdata = mtime[63:32];
      REG_MTIMECMP_LO: mmio_rdata = mtimecmp[31:0];
      REG_MTIMECMP_HI: mmio_rdata = mtimecmp[63:32];
      default:         mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime        <= '0;
      mtimecmp     <= '1;
      irq_timer    <= 1'b0;
      sel_mmio_q   <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      mtime      <= mtime_d;
      mtimecmp   <= mtimecmp_d;
      irq_timer  <= (mtime >= mtimecmp);
      sel_mmio_q <= core_re && mmio_hit;
      if (core_re) mmio_rdata_q <= mmio_rdata;
    end
  end

  assign core_rdata = sel_mmio_q ? mmio_rdata_q : bram_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic, checked
// against a frame-schedule model of the UART and an arithmetic timer model.
module tb_dmem_responder;

  localparam int unsigned BAUD  = 4;
  localparam int unsigned FRAME = 10 * BAUD;
  localparam logic [31:0] MMIO  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] core_addr = '0;
  logic [3:0]  core_we = '0;
  logic [31:0] core_wdata = '0;
  logic        core_re = 1'b0;
  logic [31:0] core_rdata, bram_addr, bram_wdata;
  logic [3:0]  bram_we;
  logic [31:0] bram_rdata = '0;
  logic        uart_tx, irq_timer;

  dmem_responder #(
    .MMIO_BASE  (MMIO),
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_addr  (core_addr),
    .core_we    (core_we),
    .core_wdata (core_wdata),
    .core_re    (core_re),
    .core_rdata (core_rdata),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata),
    .uart_tx    (uart_tx),
    .irq_timer  (irq_timer)
  );

  always #5 clk = ~clk;

  // Each accepted byte owns one frame slot on the line, identified by its start cycle.
  typedef struct {
    int unsigned start;
    logic [7:0]  data;
  } frame_t;

  frame_t      frames[$];
  int unsigned cyc = 0;
  int unsigned line_end = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] m_mtime = '0;
  logic [63:0] m_cmp = '1;
  logic        m_ovf = 1'b0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned waiting_after(int unsigned c);
    int unsigned n = 0;
    foreach (frames[i]) if (frames[i].start > c) n++;
    return n;
  endfunction

  function automatic logic m_busy(int unsigned c);
    foreach (frames[i]) if (frames[i].start <= c && c < frames[i].start + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_line(int unsigned c);
    foreach (frames[i]) begin
      if (frames[i].start <= c && c < frames[i].start + FRAME) begin
        int unsigned slot;
        slot = (c - frames[i].start) / BAUD;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return frames[i].data[slot-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status(int unsigned c);
    int unsigned n;
    n = waiting_after(c);
    return {24'h0, 4'(n), m_ovf, (n == 0), (n == 8), m_busy(c)};
  endfunction

  function automatic logic [31:0] m_read(logic [5:0] sel);
    case (sel)
      6'd1:    return m_status(cyc);
      6'd2:    return m_mtime[31:0];
      6'd3:    return m_mtime[63:32];
      6'd4:    return m_cmp[31:0];
      6'd5:    return m_cmp[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    frames.delete();
    line_end = 0;
    m_ovf    = 1'b0;
    m_mtime  = '0;
    m_cmp    = '1;
  endtask

  task automatic model_push(logic [7:0] d);
    frame_t f;
    if (waiting_after(cyc + 1) < 8) begin
      f.start  = (line_end > cyc + 2) ? line_end : cyc + 2;
      f.data   = d;
      frames.push_back(f);
      line_end = f.start + FRAME;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  // One clock cycle with whatever request is currently driven.
  task automatic tick();
    logic        hit, rd_pending, rd_bram, irq_exp;
    logic [5:0]  sel;
    logic [31:0] rd_exp;
    logic [63:0] nt;
    #1;
    hit = (core_addr[31:16] == 16'hFFFF);
    sel = core_addr[7:2];
    bram_rdata = $urandom;
    check("bram_we", bram_we, hit ? 4'h0 : core_we);
    check("bram_pass", {bram_addr, bram_wdata}, {core_addr, core_wdata});
    rd_pending = core_re && rst_n;
    rd_bram    = !hit;
    rd_exp     = hit ? m_read(sel) : 32'h0;
    irq_exp    = rst_n && (m_mtime >= m_cmp);
    if (rst_n && hit && core_we[0] && sel == 6'd0) model_push(core_wdata[7:0]);
    if (rst_n && hit && core_we[0] && sel == 6'd1 && core_wdata[3]) m_ovf = 1'b0;
    nt = m_mtime + 64'd1;
    for (int b = 0; b < 4; b++) begin
      if (rst_n && hit && core_we[b]) begin
        if (sel == 6'd2) nt[8*b +: 8]      = core_wdata[8*b +: 8];
        if (sel == 6'd3) nt[32+8*b +: 8]   = core_wdata[8*b +: 8];
        if (sel == 6'd4) m_cmp[8*b +: 8]   = core_wdata[8*b +: 8];
        if (sel == 6'd5) m_cmp[32+8*b +: 8] = core_wdata[8*b +: 8];
      end
    end
    if (rst_n) m_mtime = nt;
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    #1;
    check("uart_tx", uart_tx, m_line(cyc));
    check("irq_timer", irq_timer, irq_exp);
    if (rd_pending) check(rd_bram ? "rdata_bram" : "rdata_mmio", core_rdata,
                          rd_bram ? bram_rdata : rd_exp);
    while (frames.size() > 0 && frames[0].start + FRAME <= cyc) void'(frames.pop_front());
  endtask

  task automatic req(logic [31:0] addr, logic [3:0] we, logic [31:0] wdata, logic re);
    core_addr  = addr;
    core_we    = we;
    core_wdata = wdata;
    core_re    = re;
    tick();
    core_addr  = '0;
    core_we    = '0;
    core_wdata = '0;
    core_re    = 1'b0;
  endtask

  task automatic drain(string tag);
    int unsigned guard = 0;
    while (cyc < line_end + 2 && guard < 1000) begin
      tick();
      guard++;
    end
    check(tag, guard < 1000, 1'b1);
  endtask

  initial begin
    int unsigned busy_cycles;

    model_reset();
    repeat (3) tick();
    check("rst_rdata_follows_bram", core_rdata, bram_rdata);
    check("rst_uart_tx", uart_tx, 1'b1);
    rst_n = 1'b1;

    req(MMIO | 32'h04, 4'h0, 32'h0, 1'b1);
    check("status_after_reset", core_rdata, 32'h4);

    // Timer interrupt against a compare value of 20.
    req(MMIO | 32'h14, 4'hF, 32'h0, 1'b0);
    req(MMIO | 32'h10, 4'hF, 32'd20, 1'b0);
    for (int g = 0; g < 100 && m_mtime != 64'd20; g++) tick();
    check("mtime_reached_20", m_mtime, 64'd20);
    check("irq_low_at_20", irq_timer, 1'b0);
    tick();
    check("irq_high_after_20", irq_timer, 1'b1);
    req(MMIO | 32'h10, 4'hF, 32'hFFFF_FFFF, 1'b0);
    tick();
    check("irq_dropped", irq_timer, 1'b0);

    // MTIME write wins over that cycle's increment.
    req(MMIO | 32'h08, 4'hF, 32'h10, 1'b0);
    req(MMIO | 32'h08, 4'h0, 32'h0, 1'b1);
    check("mtime_written", core_rdata, 32'h10);
    req(MMIO | 32'h08, 4'h0, 32'h0, 1'b1);
    check("mtime_next", core_rdata, 32'h11);

    // BRAM passthrough leaves MMIO state alone.
    req(32'h100, 4'b0011, $urandom, 1'b0);
    req(32'h100, 4'h0, 32'h0, 1'b1);
    req(MMIO | 32'h10, 4'h0, 32'h0, 1'b1);
    check("cmp_lo_unchanged", core_rdata, 32'hFFFF_FFFF);
    req(MMIO | 32'h04, 4'h0, 32'h0, 1'b1);
    check("status_unchanged", core_rdata, 32'h4);

    // Single frame of 0xA5; tx_busy sampled through STATUS every cycle.
    req(MMIO | 32'h00, 4'h1, 32'hA5, 1'b0);
    busy_cycles = 0;
    for (int k = 0; k < 46; k++) begin
      req(MMIO | 32'h04, 4'h0, 32'h0, 1'b1);
      if (core_rdata[0]) busy_cycles++;
    end
    check("busy_40_cycles", busy_cycles, 40);

    // Nine pushes while a frame is on the line: eight fit, one overflows.
    req(MMIO | 32'h00, 4'h1, 32'h11, 1'b0);
    repeat (3) tick();
    for (int k = 0; k < 9; k++) req(MMIO | 32'h00, 4'h1, $urandom, 1'b0);
    req(MMIO | 32'h04, 4'h0, 32'h0, 1'b1);
    check("status_full_ovf", core_rdata, 32'h8B);
    req(MMIO | 32'h04, 4'h1, 32'h08, 1'b0);
    req(MMIO | 32'h04, 4'h0, 32'h0, 1'b1);
    check("status_ovf_cleared", core_rdata, 32'h83);
    check("frames_queued", frames.size(), 9);
    drain("drain_fifo");
    req(MMIO | 32'h04, 4'h0, 32'h0, 1'b1);
    check("status_drained", core_rdata, 32'h4);

    // Random mixed traffic.
    for (int i = 0; i < 400; i++) begin
      int unsigned kind;
      logic [31:0] a, d;
      logic [3:0]  w;
      logic        r;
      logic [5:0]  sel;
      kind = $urandom_range(0, 9);
      d    = $urandom;
      w    = 4'($urandom);
      r    = 1'($urandom);
      if (kind < 4) begin
        a = $urandom;
        if (a[31:16] == 16'hFFFF) a[16] = 1'b0;
        req(a, w, d, r);
      end else if (kind < 8) begin
        sel = 6'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) sel = 6'($urandom);
        if ((sel == 6'd2 || sel == 6'd3) && $urandom_range(0, 3) != 0) w = 4'h0;
        a = MMIO | {24'h0, sel, 2'b00};
        req(a, w, d, r);
      end else begin
        tick();
      end
    end
    drain("drain_random");

    // Asynchronous reset in the middle of a frame.
    req(MMIO | 32'h00, 4'h1, 32'h3C, 1'b0);
    repeat (12) tick();
    check("line_low_in_data", uart_tx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx_high", uart_tx, 1'b1);
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    req(MMIO | 32'h04, 4'h0, 32'h0, 1'b1);
    check("status_after_midframe_reset", core_rdata, 32'h4);
    req(MMIO | 32'h08, 4'h0, 32'h0, 1'b1);
    check("mtime_small_after_reset", core_rdata < 32'd10, 1'b1);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
